polyvec_ntt_seq: RTL and testbench
==================================

POLYVEC_NTT_SEQ -- requirements
Module: polyvec_ntt_seq

Interface
REQ-001 SHALL have parameter K, default 3, meaning polynomials per vector (legal 2..4).
REQ-002 SHALL have parameter LANES, default 1, meaning coefficients streamed per cycle (legal 1, 2, 4).
REQ-003 SHALL have parameter RD_LAT, default 1, meaning cycles from core_read_o to first valid core_dout_i.
REQ-004 SHALL have parameter TIMEOUT, default 4096, meaning maximum cycles in RUN before error.
REQ-005 SHALL have one clock; reset is asynchronous and active-low (clk_i, rst_n_i).
REQ-006 Ports, in order:
- clk_i  in  1  clock.
- rst_n_i  in  1  async active-low reset.
- start_i  in  1  operation request.
- mode_i  in  2  vec_op_t: VEC_NTT=0, VEC_INTT=1, VEC_PWM=2, VEC_PWM_ACC=3.
- polyvec_a_i  in  K*256*12  operand A vector.
- polyvec_b_i  in  K*256*12  operand B vector (PWM modes only).
- busy_o  out  1  operation in progress.
- done_o  out  1  one-cycle completion pulse.
- err_o  out  1  sticky timeout flag, cleared by the next accepted start.
- polyvec_c_o  out  K*256*12  result vector.
- core_load_a_o  out  1  core load-A strobe, held for the whole load window.
- core_load_b_o  out  1  core load-B strobe, held for the whole load window.
- core_din_o  out  LANES*12  coefficient stream to core.
- core_op_o  out  3  one-hot pulse {intt, pwm, ntt}.
- core_read_o  out  1  read-request pulse.
- core_dout_i  in  LANES*12  coefficient stream from core.
- core_done_i  in  1  core completion pulse.

Function
REQ-007 SHALL accept start_i only when busy_o=0; mode_i, polyvec_a_i and polyvec_b_i SHALL be latched at the accepting edge; start_i while busy SHALL be ignored.
REQ-008 FSM states SHALL be IDLE, LOAD_B, LOAD_A, RUN, READ, NEXT, ERR.
REQ-009 Transitions:
- IDLE->LOAD_B on start in PWM modes; IDLE->LOAD_A otherwise.
- LOAD_B->LOAD_A and LOAD_A->RUN after exactly 256/LANES cycles each.
- RUN->READ on core_done_i.
- READ->NEXT after 256/LANES captured beats.
- NEXT->LOAD_B or LOAD_A with k+1 while k<K-1; NEXT->IDLE otherwise.
- RUN->ERR when the RUN cycle counter reaches TIMEOUT; ERR->IDLE after one cycle.
REQ-010 Coefficients SHALL stream highest index first; lane 0 carries the highest index of each beat. Capture order SHALL be index 0 first.
REQ-011 core_op_o SHALL pulse exactly one cycle, on the first RUN cycle.
REQ-012 core_read_o SHALL pulse on the first READ cycle; capture SHALL begin RD_LAT cycles later.
REQ-013 VEC_NTT, VEC_INTT and VEC_PWM SHALL write captured poly k to polyvec_c_o slot k.
REQ-014 VEC_PWM_ACC SHALL write poly 0 to slot 0 and add each poly k>0 into slot 0 mod 3329 (13-bit sum, subtract 3329 if >=3329); slots 1..K-1 SHALL be zero.
REQ-015 done_o SHALL pulse on the NEXT->IDLE cycle and on the ERR cycle; busy_o SHALL be 1 in every non-IDLE state.
REQ-016 core_done_i outside RUN SHALL be ignored.
REQ-017 Total latency for VEC_NTT with no error SHALL be K*(2*256/LANES + T_core + RD_LAT + 2) cycles from start to done_o, where T_core is the core RUN duration.
REQ-018 ERR SHALL set err_o and SHALL leave polyvec_c_o slots >=k unchanged.

Reset
REQ-019 Reset assertion at any time, including mid-operation, SHALL force IDLE and SHALL zero every output, polyvec_c_o, all counters, the latched operands and err_o.
REQ-020 The first start SHALL be accepted on the second clock edge after rst_n_i deasserts.

Structure
REQ-021 vec_op_t, the constants Q=3329, N=256 and COEF_W=12, and the core-op encoding SHALL live in the shared types package.
REQ-022 One sub-module, polyvec_acc_modq (LANES-wide modular add/pass-through), SHALL be instantiated; the NTT core SHALL stay external.

Verification
REQ-023 K=3, LANES=1, VEC_NTT, zero-latency core model (dout=din+1): done_o after the REQ-017 cycle count; every slot equals input+1.
REQ-024 VEC_PWM_ACC, K=2, core model returns 3000 for poly 0 and 500 for poly 1 at all coefficients: slot 0 = 171, slot 1 = 0.
REQ-025 Core never asserts core_done_i, TIMEOUT=16: err_o=1 and done_o pulses once; a subsequent VEC_NTT start clears err_o and completes.
REQ-026 Reset pulled low during READ of k=1: all outputs read 0 within the same cycle; busy_o=0 after release.
REQ-027 start_i held high through an entire VEC_INTT run, LANES=4: exactly one operation executes; each load window is 64 cycles.
REQ-028 Spurious core_done_i in LOAD_A: ignored, and the load window still lasts exactly 256/LANES cycles.

Source files
------------

// File: rtl/polyvec_ntt_seq_pkg.sv
// Shared types and constants for the polynomial-vector NTT sequencer.
//   vec_op_t     : vector operation requested on mode_i
//   seq_state_t  : sequencer FSM states
//   CORE_OP_*    : one-hot core operation codes {intt, pwm, ntt}
//   add_modq()   : single-coefficient modular add used for accumulation
package polyvec_ntt_seq_pkg;

  localparam int Q      = 3329;
  localparam int N      = 256;
  localparam int COEF_W = 12;

  localparam logic [COEF_W:0] Q13 = 13'(Q);

  typedef enum logic [1:0] {
    VEC_NTT     = 2'd0,
    VEC_INTT    = 2'd1,
    VEC_PWM     = 2'd2,
    VEC_PWM_ACC = 2'd3
  } vec_op_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_B = 3'd1,
    LOAD_A = 3'd2,
    RUN    = 3'd3,
    READ   = 3'd4,
    NEXT   = 3'd5,
    ERR    = 3'd6
  } seq_state_t;

  localparam logic [2:0] CORE_OP_NTT  = 3'b001;
  localparam logic [2:0] CORE_OP_PWM  = 3'b010;
  localparam logic [2:0] CORE_OP_INTT = 3'b100;

  function automatic logic [2:0] core_op_code(input vec_op_t op);
    logic [2:0] code;
    case (op)
      VEC_NTT:  code = CORE_OP_NTT;
      VEC_INTT: code = CORE_OP_INTT;
      default:  code = CORE_OP_PWM;
    endcase
    return code;
  endfunction

  // 13-bit sum, one conditional subtraction of q.
  function automatic logic [COEF_W-1:0] add_modq(input logic [COEF_W-1:0] a,
                                                 input logic [COEF_W-1:0] b);
    logic [COEF_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= Q13) s = s - Q13;
    return s[COEF_W-1:0];
  endfunction

endpackage

// File: rtl/polyvec_acc_modq.sv
// LANES-wide capture datapath: either passes the captured beat through or
// adds it, lane by lane, to the value already held in the destination slot.
//   acc_en_i : 1 = modular accumulate, 0 = pass new_i through
//   old_i    : current destination coefficients (lane l at bits l*COEF_W)
//   new_i    : captured coefficients from the core
//   sum_o    : value to write back
module polyvec_acc_modq
  import polyvec_ntt_seq_pkg::*;
#(
  parameter int LANES = 1
) (
  input  logic                      acc_en_i,
  input  logic [LANES*COEF_W-1:0]   old_i,
  input  logic [LANES*COEF_W-1:0]   new_i,
  output logic [LANES*COEF_W-1:0]   sum_o
);

  always_comb begin
    sum_o = new_i;
    if (acc_en_i) begin
      for (int l = 0; l < LANES; l++) begin
        sum_o[l*COEF_W +: COEF_W] = add_modq(old_i[l*COEF_W +: COEF_W],
                                             new_i[l*COEF_W +: COEF_W]);
      end
    end
  end

endmodule

// File: rtl/polyvec_ntt_seq.sv
// Sequencer that feeds K polynomials through an external NTT/PWM core one at
// a time and assembles the results into polyvec_c_o.
//   start_i/mode_i/polyvec_a_i/polyvec_b_i : request, latched when idle
//   busy_o/done_o/err_o                    : status (err_o sticky until next start)
//   polyvec_c_o                            : result vector
//   core_*                                 : streaming interface to the core
//
// state  | meaning
// IDLE   | waiting for start_i
// LOAD_B | streaming operand B poly k to the core (PWM modes)
// LOAD_A | streaming operand A poly k to the core
// RUN    | core busy; op pulse on first cycle, timeout down-counter running
// READ   | read pulse, RD_LAT wait, capture of 256/LANES beats
// NEXT   | advance k or finish
// ERR    | core timeout, one cycle
module polyvec_ntt_seq
  import polyvec_ntt_seq_pkg::*;
#(
  parameter int K       = 3,
  parameter int LANES   = 1,
  parameter int RD_LAT  = 1,
  parameter int TIMEOUT = 4096
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic                      start_i,
  input  logic [1:0]                mode_i,
  input  logic [K*N*COEF_W-1:0]     polyvec_a_i,
  input  logic [K*N*COEF_W-1:0]     polyvec_b_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      err_o,
  output logic [K*N*COEF_W-1:0]     polyvec_c_o,
  output logic                      core_load_a_o,
  output logic                      core_load_b_o,
  output logic [LANES*COEF_W-1:0]   core_din_o,
  output logic [2:0]                core_op_o,
  output logic                      core_read_o,
  input  logic [LANES*COEF_W-1:0]   core_dout_i,
  input  logic                      core_done_i
);

  localparam int VW     = K * N * COEF_W;
  localparam int SLOT_W = N * COEF_W;
  localparam int LW     = LANES * COEF_W;
  localparam int BEATS  = N / LANES;
  localparam int TMAX   = (TIMEOUT > RD_LAT + BEATS) ? TIMEOUT : RD_LAT + BEATS;
  localparam int TW     = $clog2(TMAX + 1);
  localparam int KW     = $clog2(K);
  localparam int BW     = $clog2(BEATS);

  seq_state_t      state_q, state_d;
  vec_op_t         mode_q;
  logic [VW-1:0]   a_q, b_q, c_q;
  logic [KW-1:0]   k_q, k_d;
  logic [TW-1:0]   tmr_q, tmr_d;
  logic            err_q;
  logic            cap_vld_q, cap_vld_d;
  logic [BW-1:0]   cap_idx_q, cap_idx_d;
  logic [LW-1:0]   cap_data_q;

  logic            accept;
  logic            pwm_mode;
  logic            acc_en;
  int              slot;
  int              wr_base;
  int              acc_base;
  int              src_idx;
  logic [LW-1:0]   acc_old;
  logic [LW-1:0]   acc_sum;

  assign accept   = (state_q == IDLE) && start_i;
  assign pwm_mode = mode_q[1];

  // One shared down-counter times the load windows, the RUN timeout and READ.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    tmr_d   = tmr_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = mode_i[1] ? LOAD_B : LOAD_A;
          k_d     = '0;
          tmr_d   = TW'(BEATS - 1);
        end
      end
      LOAD_B: begin
        if (tmr_q == '0) begin
          state_d = LOAD_A;
          tmr_d   = TW'(BEATS - 1);
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      LOAD_A: begin
        if (tmr_q == '0) begin
          state_d = RUN;
          tmr_d   = TW'(TIMEOUT - 1);
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      RUN: begin
        if (core_done_i) begin
          state_d = READ;
          tmr_d   = TW'(RD_LAT + BEATS);
        end else if (tmr_q == '0) begin
          state_d = ERR;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      READ: begin
        if (tmr_q == '0) state_d = NEXT;
        else             tmr_d   = tmr_q - 1'b1;
      end
      NEXT: begin
        if (k_q == KW'(K - 1)) begin
          state_d = IDLE;
        end else begin
          k_d     = k_q + 1'b1;
          state_d = pwm_mode ? LOAD_B : LOAD_A;
          tmr_d   = TW'(BEATS - 1);
        end
      end
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // READ spans RD_LAT + BEATS + 1 cycles: beats arrive while tmr is in
  // [BEATS..1], are registered, and written one cycle later.
  always_comb begin
    cap_vld_d = (state_q == READ) && (tmr_q != '0) && (tmr_q <= TW'(BEATS));
    cap_idx_d = BW'(BEATS - int'(tmr_q));
  end

  always_comb begin
    busy_o        = (state_q != IDLE);
    done_o        = ((state_q == NEXT) && (k_q == KW'(K - 1))) || (state_q == ERR);
    err_o         = err_q;
    polyvec_c_o   = c_q;
    core_load_a_o = (state_q == LOAD_A);
    core_load_b_o = (state_q == LOAD_B);
    core_op_o     = ((state_q == RUN) && (tmr_q == TW'(TIMEOUT - 1))) ?
                    core_op_code(mode_q) : 3'b000;
    core_read_o   = (state_q == READ) && (tmr_q == TW'(RD_LAT + BEATS));
  end

  // Highest index first: beat tmr carries indices tmr*LANES+LANES-1 .. tmr*LANES,
  // with lane 0 holding the highest one.
  always_comb begin
    core_din_o = '0;
    src_idx    = 0;
    if ((state_q == LOAD_A) || (state_q == LOAD_B)) begin
      for (int l = 0; l < LANES; l++) begin
        src_idx = (int'(k_q) * N + int'(tmr_q) * LANES + (LANES - 1 - l)) * COEF_W;
        core_din_o[l*COEF_W +: COEF_W] = (state_q == LOAD_A) ?
                                         a_q[src_idx +: COEF_W] :
                                         b_q[src_idx +: COEF_W];
      end
    end
  end

  // Capture is ascending: lane l of capture beat j lands at index j*LANES+l.
  always_comb begin
    acc_en   = (mode_q == VEC_PWM_ACC) && (k_q != '0);
    slot     = (mode_q == VEC_PWM_ACC) ? 0 : int'(k_q);
    wr_base  = (slot * N + int'(cap_idx_q) * LANES) * COEF_W;
    acc_base = int'(cap_idx_q) * LANES * COEF_W;
  end

  assign acc_old = c_q[acc_base +: LW];

  polyvec_acc_modq #(
    .LANES (LANES)
  ) u_acc (
    .acc_en_i (acc_en),
    .old_i    (acc_old),
    .new_i    (cap_data_q),
    .sum_o    (acc_sum)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      mode_q     <= VEC_NTT;
      a_q        <= '0;
      b_q        <= '0;
      c_q        <= '0;
      k_q        <= '0;
      tmr_q      <= '0;
      err_q      <= 1'b0;
      cap_vld_q  <= 1'b0;
      cap_idx_q  <= '0;
      cap_data_q <= '0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      tmr_q      <= tmr_d;
      cap_vld_q  <= cap_vld_d;
      cap_idx_q  <= cap_idx_d;
      cap_data_q <= core_dout_i;
      if (accept) begin
        mode_q <= vec_op_t'(mode_i);
        a_q    <= polyvec_a_i;
        b_q    <= polyvec_b_i;
        err_q  <= 1'b0;
        // Accumulate mode only ever writes slot 0; the rest must read zero.
        if (vec_op_t'(mode_i) == VEC_PWM_ACC) c_q[VW-1:SLOT_W] <= '0;
      end
      if ((state_q == RUN) && (state_d == ERR)) err_q <= 1'b1;
      if (cap_vld_q) c_q[wr_base +: LW] <= acc_sum;
    end
  end

endmodule

// File: tb/tb_polyvec_ntt_seq.sv
module tb_polyvec_ntt_seq;

  localparam int CW = 12;
  localparam int N  = 256;
  localparam int K0 = 3;
  localparam int L0 = 1;
  localparam int K1 = 2;
  localparam int L1 = 4;
  localparam int W0 = K0 * N * CW;
  localparam int W1 = K1 * N * CW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vec_cnt = 0;
  int miscmp  = 0;

  // dut0: K=3, LANES=1, RD_LAT=1
  logic           rst0_n, start0, busy0, done0, err0, la0, lb0, rd0, cdone0;
  logic [1:0]     mode0;
  logic [W0-1:0]  a0, b0, c0;
  logic [L0*CW-1:0] din0, dout0;
  logic [2:0]     op0;

  // dut1: K=2, LANES=4, RD_LAT=1, TIMEOUT=16
  logic           rst1_n, start1, busy1, done1, err1, la1, lb1, rd1, cdone1;
  logic [1:0]     mode1;
  logic [W1-1:0]  a1, b1, c1;
  logic [L1*CW-1:0] din1, dout1;
  logic [2:0]     op1;

  polyvec_ntt_seq #(.K(K0), .LANES(L0), .RD_LAT(1), .TIMEOUT(64)) dut0 (
    .clk_i(clk), .rst_n_i(rst0_n), .start_i(start0), .mode_i(mode0),
    .polyvec_a_i(a0), .polyvec_b_i(b0), .busy_o(busy0), .done_o(done0),
    .err_o(err0), .polyvec_c_o(c0), .core_load_a_o(la0), .core_load_b_o(lb0),
    .core_din_o(din0), .core_op_o(op0), .core_read_o(rd0),
    .core_dout_i(dout0), .core_done_i(cdone0));

  polyvec_ntt_seq #(.K(K1), .LANES(L1), .RD_LAT(1), .TIMEOUT(16)) dut1 (
    .clk_i(clk), .rst_n_i(rst1_n), .start_i(start1), .mode_i(mode1),
    .polyvec_a_i(a1), .polyvec_b_i(b1), .busy_o(busy1), .done_o(done1),
    .err_o(err1), .polyvec_c_o(c1), .core_load_a_o(la1), .core_load_b_o(lb1),
    .core_din_o(din1), .core_op_o(op1), .core_read_o(rd1),
    .core_dout_i(dout1), .core_done_i(cdone1));

  // Core model 0: stores loaded coefficients, returns coef+1 in index order,
  // first beat one cycle after the read pulse, done one cycle after op (T_core=2).
  logic [CW-1:0] mem0 [N];
  logic          c0_done_q, c0_rd_act, c0_spur;
  logic [7:0]    c0_ld, c0_ri;
  always @(posedge clk or negedge rst0_n) begin
    if (!rst0_n) begin
      c0_done_q <= 1'b0; c0_rd_act <= 1'b0; c0_ld <= 8'd0; c0_ri <= 8'd0;
    end else begin
      c0_done_q <= (op0 != 3'b000);
      if (la0) begin
        mem0[8'd255 - c0_ld] <= din0;
        c0_ld <= c0_ld + 8'd1;
      end
      if (rd0) begin
        c0_rd_act <= 1'b1; c0_ri <= 8'd0;
      end else if (c0_rd_act) begin
        c0_ri <= c0_ri + 8'd1;
        if (c0_ri == 8'd255) c0_rd_act <= 1'b0;
      end
    end
  end
  assign dout0  = c0_rd_act ? mem0[c0_ri] + 12'd1 : '0;
  assign cdone0 = c0_done_q | c0_spur;

  // Core model 1: returns 3000 for the first poly of an operation, 500 after.
  logic       c1_done_q, c1_hang;
  logic [1:0] c1_p;
  always @(posedge clk or negedge rst1_n) begin
    if (!rst1_n) begin
      c1_done_q <= 1'b0; c1_p <= 2'd0;
    end else begin
      c1_done_q <= (op1 != 3'b000) && !c1_hang;
      if (start1 && !busy1) c1_p <= 2'd0;
      else if (rd1)         c1_p <= c1_p + 2'd1;
    end
  end
  assign dout1  = (c1_p == 2'd1) ? {L1{12'd3000}} : {L1{12'd500}};
  assign cdone1 = c1_done_q;

  function automatic int first_diff(input logic [N*CW-1:0] g, input logic [N*CW-1:0] e);
    for (int i = 0; i < N; i++) if (g[i*CW +: CW] !== e[i*CW +: CW]) return i;
    return 0;
  endfunction

  task automatic test_reset();
    #12;
    vec_cnt++;
    if ({busy0, done0, err0, la0, lb0, rd0, busy1, done1, err1} !== 9'b0) begin
      miscmp++; $display("FAIL reset_status got %b expected 0", {busy0, done0, err0, la0, lb0, rd0, busy1, done1, err1});
    end
    vec_cnt++;
    if ((op0 !== 3'b000) || (din0 !== '0) || (c0 !== '0) || (c1 !== '0)) begin
      miscmp++; $display("FAIL reset_data op0 %0d din0 %0d expected zeros", op0, din0);
    end
    @(negedge clk); rst0_n = 1'b1; rst1_n = 1'b1;
    @(posedge clk);
  endtask

  task automatic test_ntt_latency();
    logic [N*CW-1:0] exp_slot, got_slot;
    int cycles, bad;
    @(negedge clk);
    for (int k = 0; k < K0; k++)
      for (int i = 0; i < N; i++) a0[(k*N+i)*CW +: CW] = 12'((k*97 + i*13 + 5) % 4096);
    mode0 = 2'd0; start0 = 1'b1;
    @(posedge clk); #1;
    vec_cnt++;
    if (busy0 !== 1'b1) begin miscmp++; $display("FAIL accept_second_edge busy got %0b expected 1", busy0); end
    start0 = 1'b0;
    cycles = 0;
    while (cycles < 3000) begin @(negedge clk); cycles++; if (done0 === 1'b1) break; end
    // K * (2*256 + T_core(2) + RD_LAT(1) + 2)
    vec_cnt++;
    if (cycles != 1551) begin miscmp++; $display("FAIL ntt_latency got %0d expected 1551", cycles); end
    vec_cnt++;
    if (err0 !== 1'b0) begin miscmp++; $display("FAIL ntt_err got %0b expected 0", err0); end
    for (int k = 0; k < K0; k++) begin
      for (int i = 0; i < N; i++) exp_slot[i*CW +: CW] = 12'((k*97 + i*13 + 6) % 4096);
      got_slot = c0[k*N*CW +: N*CW];
      vec_cnt++;
      if (got_slot !== exp_slot) begin
        bad = first_diff(got_slot, exp_slot); miscmp++;
        $display("FAIL ntt_slot%0d coef %0d got %0d expected %0d", k, bad, got_slot[bad*CW +: CW], exp_slot[bad*CW +: CW]);
      end
    end
    @(negedge clk);
    vec_cnt++;
    if (busy0 !== 1'b0) begin miscmp++; $display("FAIL ntt_idle_after got %0b expected 0", busy0); end
  endtask

  task automatic test_spurious_done();
    logic [N*CW-1:0] exp_slot, got_slot;
    int n, cycles, bad;
    @(negedge clk);
    for (int k = 0; k < K0; k++)
      for (int i = 0; i < N; i++) a0[(k*N+i)*CW +: CW] = 12'((4000 - k*211 - i*11) % 4096);
    mode0 = 2'd0; start0 = 1'b1;
    @(posedge clk); #1; start0 = 1'b0;
    n = 0;
    @(negedge clk);
    while (la0 && n < 400) begin
      n++;
      c0_spur = (n == 10);
      @(negedge clk);
    end
    c0_spur = 1'b0;
    vec_cnt++;
    if (n != 256) begin miscmp++; $display("FAIL spurious_load_window got %0d expected 256", n); end
    vec_cnt++;
    if (op0 !== 3'b001) begin miscmp++; $display("FAIL ntt_op_pulse got %b expected 001", op0); end
    cycles = 0;
    while (cycles < 3000) begin @(negedge clk); cycles++; if (done0 === 1'b1) break; end
    for (int k = 0; k < K0; k++) begin
      for (int i = 0; i < N; i++) exp_slot[i*CW +: CW] = 12'((4001 - k*211 - i*11) % 4096);
      got_slot = c0[k*N*CW +: N*CW];
      vec_cnt++;
      if (got_slot !== exp_slot) begin
        bad = first_diff(got_slot, exp_slot); miscmp++;
        $display("FAIL spurious_slot%0d coef %0d got %0d expected %0d", k, bad, got_slot[bad*CW +: CW], exp_slot[bad*CW +: CW]);
      end
    end
  endtask

  task automatic test_reset_mid_read();
    int rds, c;
    @(negedge clk);
    mode0 = 2'd0; start0 = 1'b1;
    @(posedge clk); #1; start0 = 1'b0;
    rds = 0;
    for (c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (rd0) rds++;
      if (rds == 2) break;
    end
    vec_cnt++;
    if (rds != 2) begin miscmp++; $display("FAIL midread_reach got %0d reads expected 2", rds); end
    repeat (5) @(negedge clk);
    #2 rst0_n = 1'b0;
    #1;
    vec_cnt++;
    if ({busy0, done0, err0, la0, lb0, rd0} !== 6'b0 || op0 !== 3'b000 || din0 !== '0) begin
      miscmp++; $display("FAIL midread_outputs got %b expected 0", {busy0, done0, err0, la0, lb0, rd0});
    end
    vec_cnt++;
    if (c0 !== '0) begin miscmp++; $display("FAIL midread_result got nonzero expected 0"); end
    @(negedge clk); rst0_n = 1'b1;
    @(negedge clk);
    vec_cnt++;
    if (busy0 !== 1'b0) begin miscmp++; $display("FAIL midread_busy_after got %0b expected 0", busy0); end
  endtask

  task automatic test_intt_hold_start();
    logic [N*CW-1:0] exp_slot, got_slot;
    int cur, win, badlen, ops, badop, dones, lbs, extra, bad;
    cur = 0; win = 0; badlen = 0; ops = 0; badop = 0; dones = 0; lbs = 0; extra = 0;
    @(negedge clk);
    mode1 = 2'd1; start1 = 1'b1;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      if (la1) cur++;
      else if (cur != 0) begin win++; if (cur != 64) badlen++; cur = 0; end
      if (lb1) lbs++;
      if (op1 != 3'b000) begin ops++; if (op1 !== 3'b100) badop++; end
      if (done1) begin dones++; start1 = 1'b0; break; end
    end
    start1 = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (busy1 || la1 || lb1) extra++;
      if (done1) dones++;
    end
    vec_cnt++;
    if (win != 2 || badlen != 0) begin miscmp++; $display("FAIL intt_windows got %0d windows %0d bad expected 2/0", win, badlen); end
    vec_cnt++;
    if (ops != 2 || badop != 0) begin miscmp++; $display("FAIL intt_op_pulses got %0d (%0d bad) expected 2", ops, badop); end
    vec_cnt++;
    if (dones != 1 || extra != 0) begin miscmp++; $display("FAIL intt_single_op got %0d dones %0d extra expected 1/0", dones, extra); end
    vec_cnt++;
    if (lbs != 0) begin miscmp++; $display("FAIL intt_no_load_b got %0d expected 0", lbs); end
    for (int k = 0; k < K1; k++) begin
      for (int i = 0; i < N; i++) exp_slot[i*CW +: CW] = (k == 0) ? 12'd3000 : 12'd500;
      got_slot = c1[k*N*CW +: N*CW];
      vec_cnt++;
      if (got_slot !== exp_slot) begin
        bad = first_diff(got_slot, exp_slot); miscmp++;
        $display("FAIL intt_slot%0d coef %0d got %0d expected %0d", k, bad, got_slot[bad*CW +: CW], exp_slot[bad*CW +: CW]);
      end
    end
  endtask

  task automatic test_pwm_acc();
    logic [N*CW-1:0] exp_slot, got_slot;
    int lbs, cycles, bad;
    lbs = 0;
    @(negedge clk);
    mode1 = 2'd3; start1 = 1'b1;
    @(posedge clk); #1; start1 = 1'b0;
    cycles = 0;
    while (cycles < 1000) begin
      @(negedge clk); cycles++;
      if (lb1) lbs++;
      if (done1 === 1'b1) break;
    end
    vec_cnt++;
    if (lbs != 128) begin miscmp++; $display("FAIL acc_load_b_cycles got %0d expected 128", lbs); end
    vec_cnt++;
    if (err1 !== 1'b0 || done1 !== 1'b1) begin miscmp++; $display("FAIL acc_done got done %0b err %0b expected 1/0", done1, err1); end
    for (int k = 0; k < K1; k++) begin
      for (int i = 0; i < N; i++) exp_slot[i*CW +: CW] = (k == 0) ? 12'd171 : 12'd0;
      got_slot = c1[k*N*CW +: N*CW];
      vec_cnt++;
      if (got_slot !== exp_slot) begin
        bad = first_diff(got_slot, exp_slot); miscmp++;
        $display("FAIL acc_slot%0d coef %0d got %0d expected %0d", k, bad, got_slot[bad*CW +: CW], exp_slot[bad*CW +: CW]);
      end
    end
  endtask

  task automatic test_timeout_recover();
    logic [N*CW-1:0] exp_slot, got_slot;
    int cycles, dones, bad;
    c1_hang = 1'b1;
    @(negedge clk);
    mode1 = 2'd0; start1 = 1'b1;
    @(posedge clk); #1; start1 = 1'b0;
    cycles = 0;
    while (cycles < 1000) begin @(negedge clk); cycles++; if (done1 === 1'b1) break; end
    // 64 load cycles + 16 RUN cycles, then the ERR cycle
    vec_cnt++;
    if (cycles != 81) begin miscmp++; $display("FAIL timeout_latency got %0d expected 81", cycles); end
    vec_cnt++;
    if (err1 !== 1'b1) begin miscmp++; $display("FAIL timeout_err got %0b expected 1", err1); end
    dones = 0;
    for (int c = 0; c < 30; c++) begin @(negedge clk); if (done1) dones++; end
    vec_cnt++;
    if (dones != 0 || busy1 !== 1'b0 || err1 !== 1'b1) begin
      miscmp++; $display("FAIL timeout_after got %0d extra dones busy %0b err %0b expected 0/0/1", dones, busy1, err1);
    end
    for (int i = 0; i < N; i++) exp_slot[i*CW +: CW] = 12'd171;
    got_slot = c1[0 +: N*CW];
    vec_cnt++;
    if (got_slot !== exp_slot) begin
      bad = first_diff(got_slot, exp_slot); miscmp++;
      $display("FAIL timeout_slot0_kept coef %0d got %0d expected 171", bad, got_slot[bad*CW +: CW]);
    end
    c1_hang = 1'b0;
    @(negedge clk);
    mode1 = 2'd0; start1 = 1'b1;
    @(posedge clk); #1; start1 = 1'b0;
    vec_cnt++;
    if (err1 !== 1'b0) begin miscmp++; $display("FAIL recover_err_clear got %0b expected 0", err1); end
    cycles = 0;
    while (cycles < 1000) begin @(negedge clk); cycles++; if (done1 === 1'b1) break; end
    vec_cnt++;
    if (done1 !== 1'b1 || err1 !== 1'b0) begin miscmp++; $display("FAIL recover_done got done %0b err %0b expected 1/0", done1, err1); end
    for (int k = 0; k < K1; k++) begin
      for (int i = 0; i < N; i++) exp_slot[i*CW +: CW] = (k == 0) ? 12'd3000 : 12'd500;
      got_slot = c1[k*N*CW +: N*CW];
      vec_cnt++;
      if (got_slot !== exp_slot) begin
        bad = first_diff(got_slot, exp_slot); miscmp++;
        $display("FAIL recover_slot%0d coef %0d got %0d expected %0d", k, bad, got_slot[bad*CW +: CW], exp_slot[bad*CW +: CW]);
      end
    end
  endtask

  initial begin
    rst0_n = 1'b0; rst1_n = 1'b0;
    start0 = 1'b0; start1 = 1'b0;
    mode0 = 2'd0; mode1 = 2'd0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    c0_spur = 1'b0; c1_hang = 1'b0;
    for (int i = 0; i < K1*N; i++) a1[i*CW +: CW] = 12'(i % 4096);
    test_reset();
    test_ntt_latency();
    test_spurious_done();
    test_reset_mid_read();
    test_intt_hold_start();
    test_pwm_acc();
    test_timeout_recover();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp);
    $finish;
  end

endmodule
